// File: rtl/uart_rx_byte.sv
// uart_rx_byte -- 8N1 UART receiver with 16x oversampling and a valid/ready
// byte output.
//
// The line is brought into the clock domain by a two-flop synchroniser. A
// tick generator divides the system clock down to OVERSAMPLE ticks per bit
// time. It is held cleared while idle, so the sampling phase is aligned to
// the start edge. The start bit is confirmed at its centre, and every later
// bit is sampled one bit time (OVERSAMPLE ticks) after the previous sample.
//
// Optional build macro: UART_RX_PARITY_EN. When it is defined, one even-parity
// bit is received between data bit 7 and the stop bit.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   rx          serial line, asynchronous to clk, idle high
//   dout        received byte (LSB is first on the wire)
//   dout_valid  byte available; held until accepted
//   dout_ready  consumer accepts dout when dout_valid && dout_ready
//   frame_err   one-cycle pulse: stop bit sampled low
//   overrun     one-cycle pulse: byte completed while dout_valid still high
//   parity_err  one-cycle pulse on parity mismatch (0 without UART_RX_PARITY_EN)
module uart_rx_byte #(
  parameter int CLOCK_FREQUENCY = 200000000,
  parameter int BAUD_RATE       = 9600,
  parameter int OVERSAMPLE      = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] dout,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);

  localparam int DIV  = CLOCK_FREQUENCY / (BAUD_RATE * OVERSAMPLE);
  localparam int TC_W = $clog2(DIV + 1);
  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam logic [TC_W-1:0] TC_LAST = TC_W'(DIV - 1);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OS_HALF = OS_W'(OVERSAMPLE / 2 - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

  state_t            state, next_state;
  logic              rx_meta, rxs;
  logic [TC_W-1:0]   tick_cnt;
  logic              tick;
  logic [OS_W-1:0]   os_cnt;
  logic              os_done, sample;
  logic [2:0]        bit_idx;
  logic [7:0]        shift_p0;
  logic              shift_en, commit_set, ferr_set;
  logic              vld_p1;
`ifdef UART_RX_PARITY_EN
  logic              par_bit_p0;
  logic              par_load, perr_set;

  // Even parity: data bits plus parity bit must hold an even number of ones.
  function automatic logic parity_bad(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction
`endif

  // Synchroniser stage; idle-high reset value avoids a false start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  // Tick generator. It is held at zero in IDLE, so the first tick of a frame
  // comes DIV clocks after the start edge is seen.
  assign tick = (tick_cnt == TC_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      tick_cnt <= '0;
    else if (state == IDLE || tick)
      tick_cnt <= '0;
    else
      tick_cnt <= tick_cnt + TC_W'(1);
  end

  // The sub-bit tick counter reaches the centre of the start bit after half a
  // bit time. After that it reaches the next bit centre every full bit time.
  assign os_done = (state == START) ? (os_cnt == OS_HALF) : (os_cnt == OS_LAST);
  assign sample  = tick && os_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      os_cnt <= '0;
    else if (state == IDLE)
      os_cnt <= '0;
    else if (tick)
      os_cnt <= os_done ? '0 : os_cnt + OS_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    shift_en   = 1'b0;
    commit_set = 1'b0;
    ferr_set   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_load   = 1'b0;
    perr_set   = 1'b0;
`endif
    case (state)
      IDLE:  if (!rxs) next_state = START;
      START: if (sample) next_state = rxs ? IDLE : DATA;
      DATA: begin
        if (sample) begin
          shift_en = 1'b1;
`ifdef UART_RX_PARITY_EN
          if (bit_idx == 3'd7) next_state = PARITY;
`else
          if (bit_idx == 3'd7) next_state = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (sample) begin
          par_load   = 1'b1;
          next_state = STOP;
        end
      end
`endif
      STOP: begin
        if (sample) begin
          if (!rxs) begin
            // A bad stop bit outranks any parity result.
            ferr_set   = 1'b1;
            next_state = BREAK;
          end else begin
            next_state = IDLE;
`ifdef UART_RX_PARITY_EN
            if (parity_bad(shift_p0, par_bit_p0))
              perr_set = 1'b1;
            else
              commit_set = 1'b1;
`else
            commit_set = 1'b1;
`endif
          end
        end
      end
      // A line held low reports one frame error, not a string of frames.
      BREAK: if (rxs) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      bit_idx <= 3'd0;
    else if (state != DATA)
      bit_idx <= 3'd0;
    else if (shift_en)
      bit_idx <= bit_idx + 3'd1;
  end

  // Deserialiser stage (p0); LSB arrives first, so bits enter at the MSB.
  always_ff @(posedge clk) begin
    if (shift_en)
      shift_p0 <= {rxs, shift_p0[7:1]};
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (par_load)
      par_bit_p0 <= rxs;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      parity_err <= 1'b0;
    else
      parity_err <= perr_set;
  end
`else
  assign parity_err = 1'b0;
`endif

  // Commit stage (p1), one cycle after the stop sample. A handshake in the
  // same cycle frees the output register, so the new byte loads without an
  // overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1     <= 1'b0;
      dout       <= 8'd0;
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      vld_p1    <= commit_set;
      frame_err <= ferr_set;
      overrun   <= 1'b0;
      if (vld_p1 && (!dout_valid || dout_ready)) begin
        dout       <= shift_p0;
        dout_valid <= 1'b1;
      end else begin
        if (vld_p1)
          overrun <= 1'b1;
        if (dout_valid && dout_ready)
          dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
`timescale 1ns/1ps
// Testbench for uart_rx_byte. The clock is scaled down so that one bit time
// is 64 clocks. The transmitter is modelled as a task that works in whole
// bit periods. Received bytes and error pulses are gathered by a monitor and
// compared with what each transmitted frame should produce.
module tb_uart_rx_byte;

  localparam int CLK_HZ = 614400;
  localparam int BAUD   = 9600;
  localparam int OS     = 16;
  localparam int DIV    = CLK_HZ / (BAUD * OS);
  localparam int BITC   = OS * DIV;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS  = 10;
`else
  localparam int NBITS  = 9;
`endif
  // Falling start edge to dout_valid: half a bit, NBITS bits, 3 clocks.
  localparam int EXP_LAT = (OS / 2 + NBITS * OS) * DIV + 3;

  logic       clk, rst_n, rx, dout_ready;
  logic [7:0] dout;
  logic       dout_valid, frame_err, overrun, parity_err;

  uart_rx_byte #(
    .CLOCK_FREQUENCY(CLK_HZ),
    .BAUD_RATE(BAUD),
    .OVERSAMPLE(OS)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx(rx),
    .dout(dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .frame_err(frame_err),
    .overrun(overrun),
    .parity_err(parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // Monitor state.
  logic [7:0] rxq[$];
  int ferr_cnt = 0, ovr_cnt = 0, perr_cnt = 0;
  int rise_cyc = 0, hi_run = 0, last_hi = 0;
  logic v_prev = 1'b0;

`ifdef UART_RX_PARITY_EN
  logic par_flip = 1'b0;
`endif

  always @(negedge clk) begin
    if (dout_valid && dout_ready) rxq.push_back(dout);
    if (frame_err)  ferr_cnt++;
    if (overrun)    ovr_cnt++;
    if (parity_err) perr_cnt++;
    if (dout_valid && !v_prev) begin
      rise_cyc = cyc;
      hi_run   = 1;
    end else if (dout_valid) begin
      hi_run++;
    end
    if (!dout_valid && v_prev) last_hi = hi_run;
    v_prev = dout_valid;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_range(input string nm, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d..%0d", nm, act, lo, hi);
    end
  endtask

  function automatic logic [31:0] q_at(input int i);
    if (i >= 0 && i < rxq.size()) return {24'd0, rxq[i]};
    return 32'hDEAD_BEEF;
  endfunction

  // Waits n rising edges, then moves 2 ns past the edge so that stimulus
  // changes away from the clock.
  task automatic wait_clk(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #2;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int bc, input int gap);
    rx = 1'b0;
    wait_clk(bc);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_clk(bc);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ par_flip;
    wait_clk(bc);
`endif
    rx = stop;
    wait_clk(bc);
    rx = 1'b1;
    wait_clk(gap);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         bc;
    int         exp_bytes;
    int         exp_ferr;
  } vec_t;

  vec_t tv[8];
  logic [7:0] exp_q[$];

  initial begin
    int n0, f0, o0, p0, start_cyc, lat, base, exp_ferr_tot;
    logic [7:0] d;
    logic st;
    int bc, gap;

    tv[0] = '{8'h00, 1'b1, 64, 1, 0};
    tv[1] = '{8'hFF, 1'b1, 64, 1, 0};
    tv[2] = '{8'h55, 1'b1, 66, 1, 0};
    tv[3] = '{8'hC3, 1'b1, 62, 1, 0};
    tv[4] = '{8'h55, 1'b1, 62, 1, 0};
    tv[5] = '{8'hC3, 1'b1, 66, 1, 0};
    tv[6] = '{8'h3C, 1'b0, 64, 0, 1};
    tv[7] = '{8'h81, 1'b1, 64, 1, 0};

    rst_n = 1'b0;
    rx = 1'b1;
    dout_ready = 1'b0;
    wait_clk(4);
    chk("reset dout", dout, 0);
    chk("reset dout_valid", dout_valid, 0);
    chk("reset frame_err", frame_err, 0);
    chk("reset overrun", overrun, 0);
    chk("reset parity_err", parity_err, 0);
    rst_n = 1'b1;
    wait_clk(4);

    // Reset with a held byte and with a frame in progress.
    send_frame(8'h99, 1'b1, BITC, 20);
    chk("held dout", dout, 8'h99);
    chk("held dout_valid", dout_valid, 1);
    rx = 1'b0;
    wait_clk(3 * BITC);
    rst_n = 1'b0;
    rx = 1'b1;
    wait_clk(3);
    chk("dout during reset", dout, 0);
    chk("dout_valid during reset", dout_valid, 0);
    wait_clk(10);
    rst_n = 1'b1;
    wait_clk(12 * BITC);
    chk("aborted frame bytes", rxq.size(), 0);
    chk("aborted frame ferr", ferr_cnt, 0);
    dout_ready = 1'b1;
    send_frame(8'h5A, 1'b1, BITC, 20);
    chk("post-reset bytes", rxq.size(), 1);
    chk("post-reset data", q_at(0), 8'h5A);
    chk("post-reset errors", ferr_cnt + ovr_cnt + perr_cnt, 0);

    // Basic receive, latency and a one-cycle valid.
    n0 = rxq.size();
    start_cyc = cyc;
    send_frame(8'hA5, 1'b1, BITC, 20);
    lat = rise_cyc - start_cyc;
    chk_range("latency", lat, EXP_LAT - 2, EXP_LAT + 2);
    chk("basic bytes", rxq.size() - n0, 1);
    chk("basic data", q_at(n0), 8'hA5);
    chk("valid width", last_hi, 1);

    // Backpressure and overrun.
    dout_ready = 1'b0;
    n0 = rxq.size();
    o0 = ovr_cnt;
    send_frame(8'h31, 1'b1, BITC, 0);
    send_frame(8'h32, 1'b1, BITC, 20);
    chk("bp dout kept", dout, 8'h31);
    chk("bp valid held", dout_valid, 1);
    chk("bp overrun pulses", ovr_cnt - o0, 1);
    chk("bp no accept", rxq.size() - n0, 0);
    dout_ready = 1'b1;
    wait_clk(3);
    dout_ready = 1'b0;
    chk("bp valid cleared", dout_valid, 0);
    chk("bp accepted", rxq.size() - n0, 1);
    chk("bp accepted data", q_at(n0), 8'h31);
    wait_clk(2 * BITC);
    chk("bp no second byte", rxq.size() - n0, 1);
    chk("bp valid stays low", dout_valid, 0);

    // Handshake in the same cycle as the commit.
    n0 = rxq.size();
    send_frame(8'h11, 1'b1, BITC, 20);
    o0 = ovr_cnt;
    fork
      send_frame(8'h22, 1'b1, BITC, 20);
      begin
        wait_clk(EXP_LAT);
        dout_ready = 1'b1;
      end
    join
    chk("same-cycle bytes", rxq.size() - n0, 2);
    chk("same-cycle first", q_at(n0), 8'h11);
    chk("same-cycle second", q_at(n0 + 1), 8'h22);
    chk("same-cycle overrun", ovr_cnt - o0, 0);

    // False start.
    n0 = rxq.size();
    f0 = ferr_cnt;
    rx = 1'b0;
    wait_clk(BITC / 4);
    rx = 1'b1;
    wait_clk(12 * BITC);
    chk("glitch bytes", rxq.size() - n0, 0);
    chk("glitch ferr", ferr_cnt - f0, 0);

    // Framing errors.
    send_frame(8'h7E, 1'b0, BITC, 20);
    chk("bad stop ferr", ferr_cnt - f0, 1);
    chk("bad stop bytes", rxq.size() - n0, 0);
    send_frame(8'h7E, 1'b0, BITC, 0);
    rx = 1'b0;
    wait_clk(5 * BITC);
    rx = 1'b1;
    wait_clk(2 * BITC);
    chk("extended low ferr", ferr_cnt - f0, 2);
    rx = 1'b0;
    wait_clk(15 * BITC);
    rx = 1'b1;
    wait_clk(2 * BITC);
    chk("break ferr", ferr_cnt - f0, 3);
    chk("break bytes", rxq.size() - n0, 0);
    send_frame(8'h41, 1'b1, BITC, 20);
    chk("after break bytes", rxq.size() - n0, 1);
    chk("after break data", q_at(n0), 8'h41);

    // Table of frames, including skewed baud rates.
    for (int i = 0; i < 8; i++) begin
      n0 = rxq.size();
      f0 = ferr_cnt;
      p0 = perr_cnt;
      o0 = ovr_cnt;
      send_frame(tv[i].data, tv[i].stop, tv[i].bc, 16);
      chk($sformatf("row%0d bytes", i), rxq.size() - n0, tv[i].exp_bytes);
      chk($sformatf("row%0d ferr", i), ferr_cnt - f0, tv[i].exp_ferr);
      chk($sformatf("row%0d perr+ovr", i), (perr_cnt - p0) + (ovr_cnt - o0), 0);
      if (tv[i].exp_bytes != 0)
        chk($sformatf("row%0d data", i), q_at(rxq.size() - 1), tv[i].data);
    end

    // Random frames.
    base = rxq.size();
    f0 = ferr_cnt;
    exp_ferr_tot = 0;
    for (int k = 0; k < 20; k++) begin
      d   = 8'($urandom);
      bc  = $urandom_range(62, 66);
      st  = ($urandom_range(0, 4) != 0);
      gap = st ? $urandom_range(0, 30) : $urandom_range(8, 30);
      if (st) exp_q.push_back(d);
      else exp_ferr_tot++;
      send_frame(d, st, bc, gap);
      chk($sformatf("rand%0d bytes", k), rxq.size() - base, exp_q.size());
      chk($sformatf("rand%0d ferr", k), ferr_cnt - f0, exp_ferr_tot);
      if (st)
        chk($sformatf("rand%0d data", k), q_at(rxq.size() - 1), d);
    end
    for (int k = 0; k < exp_q.size(); k++)
      chk($sformatf("rand seq %0d", k), q_at(base + k), exp_q[k]);

`ifdef UART_RX_PARITY_EN
    n0 = rxq.size();
    p0 = perr_cnt;
    f0 = ferr_cnt;
    par_flip = 1'b0;
    send_frame(8'h03, 1'b1, BITC, 20);
    chk("parity good bytes", rxq.size() - n0, 1);
    chk("parity good data", q_at(n0), 8'h03);
    chk("parity good perr", perr_cnt - p0, 0);
    par_flip = 1'b1;
    send_frame(8'h03, 1'b1, BITC, 20);
    chk("parity bad perr", perr_cnt - p0, 1);
    chk("parity bad bytes", rxq.size() - n0, 1);
    chk("parity bad valid", dout_valid, 0);
    send_frame(8'h03, 1'b0, BITC, 20);
    chk("parity+stop ferr", ferr_cnt - f0, 1);
    chk("parity+stop perr", perr_cnt - p0, 1);
    par_flip = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
